// File: rtl/rv_pkg.sv
// Shared types for the RV32 instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   pc_state_e      - PC generator FSM states
//   redir_kind_e    - kind of a buffered redirect (branch/jump or trap)
//   PC_RESET_VECTOR - default fetch address after reset
package rv_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  typedef enum logic {
    REDIR_BRANCH = 1'b0,
    REDIR_TRAP   = 1'b1
  } redir_kind_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0060;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer: keeps one redirect/trap that arrived while fetch was stalled.
// Latency: 1 cycle from capture to pend_valid/pend_kind/pend_target.
// Backpressure: none; it only records events while capture is high and drops them on clear.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   capture          - record incoming events this cycle (fetch stalled)
//   clear            - drop the entry (it has been consumed); wins over capture
//   trap_valid/trap_vector         - incoming trap event
//   redirect_valid/redirect_target - incoming branch/jump event
//   pend_valid/pend_kind/pend_target - buffered entry
module pc_redirect_buf
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             clear,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             pend_valid,
  output redir_kind_e      pend_kind,
  output logic [WIDTH-1:0] pend_target
);

  // A trap always takes the slot. A branch only takes it when no trap is
  // parked there, so a later redirect can never shadow an earlier trap.
  logic branch_may_write;
  assign branch_may_write = !(pend_valid && (pend_kind == REDIR_TRAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_kind   <= REDIR_BRANCH;
      pend_target <= '0;
    end else if (clear) begin
      pend_valid  <= 1'b0;
      pend_kind   <= REDIR_BRANCH;
      pend_target <= '0;
    end else if (capture) begin
      if (trap_valid) begin
        pend_valid  <= 1'b1;
        pend_kind   <= REDIR_TRAP;
        pend_target <= trap_vector;
      end else if (redirect_valid && branch_may_write) begin
        pend_valid  <= 1'b1;
        pend_kind   <= REDIR_BRANCH;
        pend_target <= redirect_target;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator with stall hold, branch/trap redirect and pending buffer.
// Latency: 1 cycle from selected target (trap > redirect > pc+INC) to pc_o.
// Backpressure: stall_i holds pc_o; redirects seen during a stall are buffered and applied on release.
//
// Ports:
//   clk, rst_n                           - core clock, asynchronous active-low reset
//   stall_i                              - fetch stall, pc_o holds
//   redirect_valid_i / redirect_target_i - single-cycle branch/jump redirect from EX
//   trap_valid_i / trap_vector_i         - single-cycle trap redirect
//   pc_o, pc_seq_o                       - registered fetch PC and its sequential successor
//   fetch_valid_o                        - pc_o is a valid fetch address
//   redirect_taken_o                     - one-cycle pulse when pc_o just loaded a redirect/trap
//   misalign_o                           - only with PC_ALIGN_CHECK_EN: taken branch target not word aligned
module pc_gen
  import rv_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int               INC          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  input  logic             trap_valid_i,
  input  logic [WIDTH-1:0] trap_vector_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_seq_o,
  output logic             fetch_valid_o,
  output logic             redirect_taken_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misalign_o
`endif
);

  pc_state_e        state_q, state_n;
  logic [WIDTH-1:0] pc_n;
  logic             fetch_valid_n;
  logic             taken_n;
  logic             buf_capture;
  logic             buf_clear;
  logic             pend_valid;
  redir_kind_e      pend_kind;
  logic [WIDTH-1:0] pend_target;
`ifdef PC_ALIGN_CHECK_EN
  logic             misalign_n;
`endif

  assign pc_seq_o = pc_o + WIDTH'(INC);

  // Events are recorded whenever fetch is stalled outside BOOT; in RUN the
  // buffer is empty, so the same overwrite rules give "trap wins" there too.
  assign buf_capture = stall_i && (state_q != BOOT);

  pc_redirect_buf #(
    .WIDTH(WIDTH)
  ) u_redirect_buf (
    .clk             (clk),
    .rst_n           (rst_n),
    .capture         (buf_capture),
    .clear           (buf_clear),
    .trap_valid      (trap_valid_i),
    .trap_vector     (trap_vector_i),
    .redirect_valid  (redirect_valid_i),
    .redirect_target (redirect_target_i),
    .pend_valid      (pend_valid),
    .pend_kind       (pend_kind),
    .pend_target     (pend_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= BOOT;
      pc_o             <= RESET_VECTOR;
      fetch_valid_o    <= 1'b0;
      redirect_taken_o <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_o       <= 1'b0;
`endif
    end else begin
      state_q          <= state_n;
      pc_o             <= pc_n;
      fetch_valid_o    <= fetch_valid_n;
      redirect_taken_o <= taken_n;
`ifdef PC_ALIGN_CHECK_EN
      misalign_o       <= misalign_n;
`endif
    end
  end

  always_comb begin
    state_n       = state_q;
    pc_n          = pc_o;
    fetch_valid_n = fetch_valid_o;
    taken_n       = 1'b0;
    buf_clear     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_n    = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        // One dead cycle: PC holds and events are ignored.
        state_n       = RUN;
        fetch_valid_n = 1'b1;
      end
      RUN: begin
        if (!stall_i) begin
          if (trap_valid_i) begin
            pc_n    = trap_vector_i;
            taken_n = 1'b1;
          end else if (redirect_valid_i) begin
            pc_n    = redirect_target_i;
            taken_n = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            misalign_n = |redirect_target_i[1:0];
`endif
          end else begin
            pc_n = pc_seq_o;
          end
        end else if (trap_valid_i || redirect_valid_i) begin
          state_n = PEND;
        end
      end
      PEND: begin
        if (!stall_i) begin
          // The buffer is always valid here, so a redirect is always taken.
          state_n   = RUN;
          taken_n   = 1'b1;
          buf_clear = 1'b1;
          if (trap_valid_i) begin
            pc_n = trap_vector_i;
          end else if (pend_valid && (pend_kind == REDIR_TRAP)) begin
            pc_n = pend_target;
          end else if (redirect_valid_i) begin
            pc_n = redirect_target_i;
`ifdef PC_ALIGN_CHECK_EN
            misalign_n = |redirect_target_i[1:0];
`endif
          end else begin
            pc_n = pend_target;
`ifdef PC_ALIGN_CHECK_EN
            misalign_n = |pend_target[1:0];
`endif
          end
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: scenario tasks push expected outputs to a scoreboard queue.
// Latency: each stimulus row is applied at posedge+1 and checked at the next posedge+1.
// Backpressure: stall_i is driven directly from the stimulus rows.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        trap_valid_i;
  logic [31:0] trap_vector_i;
  logic [31:0] pc_o;
  logic [31:0] pc_seq_o;
  logic        fetch_valid_o;
  logic        redirect_taken_o;
  logic        mis_obs;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        st;
    logic        rv;
    logic [31:0] rt;
    logic        tv;
    logic [31:0] tvec;
    logic [31:0] pc;
    logic        fv;
    logic        tk;
    logic        mis;
  } row_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] seq;
    logic        fv;
    logic        tk;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  pc_gen dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .trap_valid_i      (trap_valid_i),
    .trap_vector_i     (trap_vector_i),
    .pc_o              (pc_o),
    .pc_seq_o          (pc_seq_o),
    .fetch_valid_o     (fetch_valid_o),
    .redirect_taken_o  (redirect_taken_o)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_o        (mis_obs)
`endif
  );

`ifndef PC_ALIGN_CHECK_EN
  assign mis_obs = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic row_t mk(input logic st, input logic rv, input logic [31:0] rt,
                              input logic tv, input logic [31:0] tvec,
                              input logic [31:0] pc, input logic tk, input logic mis);
    row_t r;
    r.st = st; r.rv = rv; r.rt = rt; r.tv = tv; r.tvec = tvec;
    r.pc = pc; r.fv = 1'b1; r.tk = tk; r.mis = mis;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one row, queue its expected outputs, advance one cycle.
  task automatic apply(input row_t r);
    exp_t e;
    stall_i           = r.st;
    redirect_valid_i  = r.rv;
    redirect_target_i = r.rt;
    trap_valid_i      = r.tv;
    trap_vector_i     = r.tvec;
    e.pc  = r.pc;
    e.seq = r.pc + 32'd4;
    e.fv  = r.fv;
    e.tk  = r.tk;
    e.mis = r.mis;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0;
    trap_valid_i = 1'b0; trap_vector_i = '0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs} !== {32'h60, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: pc=%h fv=%b tk=%b mis=%b, want pc=00000060 fv=0 tk=0 mis=0",
               pc_o, fetch_valid_o, redirect_taken_o, mis_obs);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({pc_o, fetch_valid_o, redirect_taken_o} !== {32'h60, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL boot_cycle: pc=%h fv=%b tk=%b, want pc=00000060 fv=0 tk=0",
               pc_o, fetch_valid_o, redirect_taken_o);
    end
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h60, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h64, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h68, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o} !== {e.pc, e.fv, e.tk, e.mis, e.seq}) begin
        errors++;
        $display("FAIL reset_run[%0d]: pc=%h fv=%b tk=%b mis=%b seq=%h, want pc=%h fv=%b tk=%b mis=%b seq=%h",
                 i, pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o, e.pc, e.fv, e.tk, e.mis, e.seq);
      end
    end
  endtask

  task automatic test_redirect_run();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 1, 32'h200, 0, 0, 32'h200, 1, 0));
    rows.push_back(mk(0, 0, 0,       0, 0, 32'h204, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o} !== {e.pc, e.fv, e.tk, e.mis, e.seq}) begin
        errors++;
        $display("FAIL redirect_run[%0d]: pc=%h fv=%b tk=%b mis=%b seq=%h, want pc=%h fv=%b tk=%b mis=%b seq=%h",
                 i, pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o, e.pc, e.fv, e.tk, e.mis, e.seq);
      end
    end
  endtask

  task automatic test_stall_redirect();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h400, 0, 0, 32'h204, 0, 0));
    rows.push_back(mk(1, 0, 0,       0, 0, 32'h204, 0, 0));
    rows.push_back(mk(1, 0, 0,       0, 0, 32'h204, 0, 0));
    rows.push_back(mk(0, 0, 0,       0, 0, 32'h400, 1, 0));
    rows.push_back(mk(0, 0, 0,       0, 0, 32'h404, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o} !== {e.pc, e.fv, e.tk, e.mis, e.seq}) begin
        errors++;
        $display("FAIL stall_redirect[%0d]: pc=%h fv=%b tk=%b mis=%b seq=%h, want pc=%h fv=%b tk=%b mis=%b seq=%h",
                 i, pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o, e.pc, e.fv, e.tk, e.mis, e.seq);
      end
    end
  endtask

  task automatic test_pend_priority();
    row_t rows[$];
    exp_t e;
    // pending trap is not overwritten by a later redirect
    rows.push_back(mk(1, 0, 0,       1, 32'h1000, 32'h404,  0, 0));
    rows.push_back(mk(1, 1, 32'h300, 0, 0,        32'h404,  0, 0));
    rows.push_back(mk(0, 0, 0,       0, 0,        32'h1000, 1, 0));
    rows.push_back(mk(0, 0, 0,       0, 0,        32'h1004, 0, 0));
    // pending redirect is overwritten by a later trap
    rows.push_back(mk(1, 1, 32'h300, 0, 0,        32'h1004, 0, 0));
    rows.push_back(mk(1, 0, 0,       1, 32'h1000, 32'h1004, 0, 0));
    rows.push_back(mk(0, 0, 0,       0, 0,        32'h1000, 1, 0));
    // new trap on release beats a pending redirect
    rows.push_back(mk(1, 1, 32'h300, 0, 0,        32'h1000, 0, 0));
    rows.push_back(mk(0, 0, 0,       1, 32'h2000, 32'h2000, 1, 0));
    // newer redirect replaces an older pending redirect
    rows.push_back(mk(1, 1, 32'h500, 0, 0,        32'h2000, 0, 0));
    rows.push_back(mk(1, 1, 32'h540, 0, 0,        32'h2000, 0, 0));
    rows.push_back(mk(0, 0, 0,       0, 0,        32'h540,  1, 0));
    rows.push_back(mk(0, 0, 0,       0, 0,        32'h544,  0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o} !== {e.pc, e.fv, e.tk, e.mis, e.seq}) begin
        errors++;
        $display("FAIL pend_priority[%0d]: pc=%h fv=%b tk=%b mis=%b seq=%h, want pc=%h fv=%b tk=%b mis=%b seq=%h",
                 i, pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o, e.pc, e.fv, e.tk, e.mis, e.seq);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 1, 32'h300,       1, 32'h800, 32'h800,       1, 0));
    rows.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0,       32'hFFFF_FFFC, 1, 0));
    rows.push_back(mk(0, 0, 0,             0, 0,       32'h0,         0, 0));
    rows.push_back(mk(0, 0, 0,             0, 0,       32'h4,         0, 0));
    rows.push_back(mk(1, 0, 0,             0, 0,       32'h4,         0, 0));
    rows.push_back(mk(1, 0, 0,             0, 0,       32'h4,         0, 0));
    rows.push_back(mk(0, 0, 0,             0, 0,       32'h8,         0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o} !== {e.pc, e.fv, e.tk, e.mis, e.seq}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: pc=%h fv=%b tk=%b mis=%b seq=%h, want pc=%h fv=%b tk=%b mis=%b seq=%h",
                 i, pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o, e.pc, e.fv, e.tk, e.mis, e.seq);
      end
    end
  endtask

  task automatic test_reset_mid_pend();
    row_t rows[$];
    exp_t e;
    apply(mk(1, 1, 32'h500, 0, 0, 32'h8, 0, 0));
    e = exp_q.pop_front();
    checks++;
    if ({pc_o, fetch_valid_o, redirect_taken_o} !== {e.pc, e.fv, e.tk}) begin
      errors++;
      $display("FAIL pend_before_reset: pc=%h fv=%b tk=%b, want pc=%h fv=%b tk=%b",
               pc_o, fetch_valid_o, redirect_taken_o, e.pc, e.fv, e.tk);
    end
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_o, fetch_valid_o, redirect_taken_o} !== {32'h60, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: pc=%h fv=%b tk=%b, want pc=00000060 fv=0 tk=0",
               pc_o, fetch_valid_o, redirect_taken_o);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({pc_o, fetch_valid_o, redirect_taken_o} !== {32'h60, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL boot_repeat: pc=%h fv=%b tk=%b, want pc=00000060 fv=0 tk=0",
               pc_o, fetch_valid_o, redirect_taken_o);
    end
    // redirect during BOOT is ignored, and the pre-reset pending 0x500 is gone
    rows.push_back(mk(0, 1, 32'h700, 0, 0, 32'h60, 0, 0));
    rows.push_back(mk(0, 0, 0,       0, 0, 32'h64, 0, 0));
    rows.push_back(mk(0, 0, 0,       0, 0, 32'h68, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o} !== {e.pc, e.fv, e.tk, e.mis, e.seq}) begin
        errors++;
        $display("FAIL after_reset[%0d]: pc=%h fv=%b tk=%b mis=%b seq=%h, want pc=%h fv=%b tk=%b mis=%b seq=%h",
                 i, pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o, e.pc, e.fv, e.tk, e.mis, e.seq);
      end
    end
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_misalign();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 1, 32'h202, 0, 0,       32'h202, 1, 1));
    rows.push_back(mk(0, 0, 0,       0, 0,       32'h206, 0, 0));
    rows.push_back(mk(0, 0, 0,       1, 32'h20A, 32'h20A, 1, 0));
    rows.push_back(mk(1, 1, 32'h301, 0, 0,       32'h20A, 0, 0));
    rows.push_back(mk(0, 0, 0,       0, 0,       32'h301, 1, 1));
    rows.push_back(mk(0, 0, 0,       0, 0,       32'h305, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o} !== {e.pc, e.fv, e.tk, e.mis, e.seq}) begin
        errors++;
        $display("FAIL misalign[%0d]: pc=%h fv=%b tk=%b mis=%b seq=%h, want pc=%h fv=%b tk=%b mis=%b seq=%h",
                 i, pc_o, fetch_valid_o, redirect_taken_o, mis_obs, pc_seq_o, e.pc, e.fv, e.tk, e.mis, e.seq);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_redirect_run();
    test_stall_redirect();
    test_pend_priority();
    test_back_to_back();
    test_reset_mid_pend();
`ifdef PC_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the IF stage of the pipelined RV32 core; successor to the plain load-enabled PC register.
- Adds: configurable width and reset vector, fetch-stall hold, branch/jump redirect, trap redirect with fixed priority, and a pending-redirect buffer so single-cycle redirect pulses arriving during a stall are never lost.
- Drives the I-cache fetch address and the IF/ID valid/flush controls.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0060, PC value loaded on reset.
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  fetch stall; PC must hold.
- redirect_valid_i  in  1  single-cycle branch/jump redirect from EX.
- redirect_target_i  in  WIDTH  redirect address.
- trap_valid_i  in  1  single-cycle trap/exception redirect.
- trap_vector_i  in  WIDTH  trap handler address.
- pc_o  out  WIDTH  current fetch PC (registered).
- pc_seq_o  out  WIDTH  pc_o + INC, combinational, mod 2^WIDTH.
- fetch_valid_o  out  1  pc_o is a valid fetch address (registered).
- redirect_taken_o  out  1  one-cycle pulse: pc_o has just loaded a redirect/trap target; downstream flushes IF/ID.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous): pc_o=RESET_VECTOR, state=BOOT, fetch_valid_o=0, redirect_taken_o=0, pending buffer cleared. Reset mid-stall or mid-PEND discards every pending event.
- FSM states: BOOT, RUN, PEND.
- BOOT: lasts exactly 1 cycle after rst_n rises. pc_o holds and events are ignored. Next state RUN; fetch_valid_o=1 from the first RUN cycle onward.
- RUN, stall_i=0: next pc selected with priority trap_valid_i > redirect_valid_i > pc_seq_o.
  - The selected target is visible on pc_o one cycle later (latency 1).
  - redirect_taken_o=1 in that same cycle if a trap or redirect was taken.
- RUN, stall_i=1:
  - pc_o holds.
  - Any trap or redirect is latched into the pending buffer {kind, target}; next state PEND.
  - If both arrive together, the trap is latched.
- PEND, stall_i=1: pc_o holds. Buffer update rules:
  - A new trap overwrites any pending entry.
  - A new redirect overwrites a pending redirect, never a pending trap.
- PEND, stall_i=0: next pc priority is new trap > pending trap > new redirect > pending redirect. Then redirect_taken_o pulses, the buffer clears, and the next state is RUN.
- redirect_taken_o: always exactly 1 cycle; never asserted in BOOT.
- fetch_valid_o: stays 1 during stall and PEND (address held, still valid).
- Arithmetic: pc_seq_o wraps mod 2^WIDTH, with no overflow flag. Targets are loaded unmodified, with no alignment masking.
- Stalled RUN with no event: pure hold, no state change.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - A taken redirect target with bits[1:0]!=0 pulses misalign_o for 1 cycle, aligned with redirect_taken_o.
  - pc_o still loads the raw target; the trap unit consumes the flag.
  - Trap targets are not checked.
- When not defined: no port and no logic; behaviour otherwise identical.

Decomposition:
- Shared package rv_pkg holds:
  - typedef pc_state_e {BOOT, RUN, PEND};
  - typedef redir_kind_e {REDIR_BRANCH, REDIR_TRAP};
  - constant PC_RESET_VECTOR = 32'h60 (default for RESET_VECTOR).
- One sub-module is natural: pc_redirect_buf, which holds the pending {valid, kind, target} register and its overwrite rules. The FSM and PC register stay in pc_gen.

Test Plan:
- Reset then run: release rst_n; 1 BOOT cycle with pc_o=0x60 and fetch_valid_o=0; then pc_o=0x60, 0x64, 0x68 on successive cycles with fetch_valid_o=1.
- Redirect in RUN: at pc_o=0x68 pulse redirect to 0x200 -> next cycle pc_o=0x200 with redirect_taken_o=1; following cycle pc_o=0x204 with redirect_taken_o=0.
- Redirect during stall: hold stall_i 3 cycles and pulse redirect to 0x400 in stall cycle 1 -> pc_o holds; after stall drops pc_o=0x400 with a single redirect_taken_o pulse.
- Priority in PEND: during stall, pending trap 0x1000, then redirect 0x300 arrives -> after release pc_o=0x1000. Repeat with pending redirect then trap -> 0x1000.
- Simultaneous trap+redirect in RUN (0x800 and 0x300) -> pc_o=0x800. Wrap-around: redirect to 0xFFFF_FFFC -> then pc_o=0x0000_0000.
- Async reset mid-PEND: assert rst_n=0 between clock edges -> pc_o=0x60 immediately; pending redirect lost; BOOT repeats. With PC_ALIGN_CHECK_EN, redirect to 0x202 -> misalign_o pulses with pc_o=0x202.
